// File: rtl/reg_bank_reader_pkg.sv
// Shared definitions for the register-bank reader: default word width,
// FSM state encoding and the index-width helper.
package reg_bank_reader_pkg;

  localparam int unsigned WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    STREAM = 2'b01,
    DONE   = 2'b10
  } state_e;

  // Width of an element index; at least one bit so a 2-element bank still
  // gets a usable index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reader_snapshot_reg.sv
// One word of snapshot storage: WIDTH-bit register with synchronous clear
// and load enable.
module reader_snapshot_reg
  import reg_bank_reader_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Capture the incoming word only when loading, otherwise hold.
  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = d;
    end
  end

  // Storage register; clear wins over load.
  always_ff @(posedge clk) begin
    if (clear) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/reg_bank_reader.sv
// Register-bank reader: on start (in IDLE) snapshots a flat bank of N_ELEM
// words and streams them out over valid/ready, element 0 first, followed by
// a one-cycle done pulse.
// Optional build macro READER_LAST_EN adds a 'last' output marking the final
// element while it is valid.
module reg_bank_reader
  import reg_bank_reader_pkg::*;
#(
  parameter int unsigned N_ELEM = 4,
  parameter int unsigned WIDTH  = WIDTH_DEFAULT,
  localparam int unsigned IDX_W = idx_width(N_ELEM)
) (
  input  logic                    clk,
  input  logic                    clear,
  input  logic                    start,
  input  logic [N_ELEM*WIDTH-1:0] bank_in,
  output logic [WIDTH-1:0]        d_out,
  output logic                    valid,
  input  logic                    ready,
  output logic [IDX_W-1:0]        idx,
  output logic                    busy,
  output logic                    done
`ifdef READER_LAST_EN
  ,
  output logic                    last
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] idx_inc;
  logic [WIDTH-1:0] d_out_q, d_out_d;
  logic             snap_load;
  logic [WIDTH-1:0] snap_q [N_ELEM];

  // Snapshot storage, one register per bank element.
  generate
    for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_snap
      reader_snapshot_reg #(
        .WIDTH (WIDTH)
      ) u_snap (
        .clk   (clk),
        .clear (clear),
        .load  (snap_load),
        .d     (bank_in[gi*WIDTH +: WIDTH]),
        .q     (snap_q[gi])
      );
    end
  endgenerate

  // Next-state, index and data-register logic. Element 0 is taken straight
  // from bank_in at the snapshot edge so it is presented the very next
  // cycle; later elements come from the snapshot registers.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    d_out_d   = d_out_q;
    snap_load = 1'b0;
    idx_inc   = idx_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          snap_load = 1'b1;
          idx_d     = '0;
          d_out_d   = bank_in[WIDTH-1:0];
          state_d   = STREAM;
        end
      end
      STREAM: begin
        if (ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = DONE;
          end else begin
            idx_d   = idx_inc;
            d_out_d = snap_q[idx_inc];
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, index and output-data registers.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= IDLE;
      idx_q   <= '0;
      d_out_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      d_out_q <= d_out_d;
    end
  end

  assign d_out = d_out_q;
  assign idx   = idx_q;
  assign valid = (state_q == STREAM);
  assign done  = (state_q == DONE);
  assign busy  = (state_q != IDLE);

`ifdef READER_LAST_EN
  assign last = (state_q == STREAM) && (idx_q == LAST_IDX);
`endif

endmodule

// File: tb/tb_reg_bank_reader.sv
// Testbench for reg_bank_reader: directed scenarios plus randomized traffic
// checked against a queue-based model of the stream.
module tb_reg_bank_reader;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = (N <= 2) ? 1 : $clog2(N);

  logic           clk = 1'b0;
  logic           clear = 1'b0;
  logic           start = 1'b0;
  logic           ready = 1'b0;
  logic [N*W-1:0] bank_in = '0;
  logic [W-1:0]   d_out;
  logic           valid;
  logic [IW-1:0]  idx;
  logic           busy;
  logic           done;
`ifdef READER_LAST_EN
  logic           last;
`endif

  int errors = 0;
  int checks = 0;

  // Model: words still to be delivered, pending done pulse, current d_out.
  logic [W-1:0] m_q[$];
  bit           m_done = 1'b0;
  logic [W-1:0] m_d = '0;

  reg_bank_reader #(.N_ELEM(N), .WIDTH(W)) dut (
    .clk     (clk),
    .clear   (clear),
    .start   (start),
    .bank_in (bank_in),
    .d_out   (d_out),
    .valid   (valid),
    .ready   (ready),
    .idx     (idx),
    .busy    (busy),
    .done    (done)
`ifdef READER_LAST_EN
    ,
    .last    (last)
`endif
  );

  always #5 clk = ~clk;

  // Apply inputs for one edge, advance past it and update the model.
  task automatic tick(input logic s, input logic r, input logic c, input logic [N*W-1:0] b);
    start   = s;
    ready   = r;
    clear   = c;
    bank_in = b;
    @(posedge clk);
    if (c) begin
      m_q.delete();
      m_done = 1'b0;
      m_d    = '0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_q.size() > 0) begin
      if (r) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_done = 1'b1;
        else m_d = m_q[0];
      end
    end else if (s) begin
      for (int i = 0; i < N; i++) m_q.push_back(b[i*W +: W]);
      m_d = m_q[0];
    end
    #1;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1, 1'b1, 32'hA5A5_A5A5);
    tick(1'b0, 1'b0, 1'b1, 32'h0);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (idx !== '0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", idx); end
    checks++; if (d_out !== 8'h00) begin errors++; $display("FAIL reset_dout got=%h exp=00", d_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
`ifdef READER_LAST_EN
    checks++; if (last !== 1'b0) begin errors++; $display("FAIL reset_last got=%b exp=0", last); end
`endif
    tick(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_basic();
    logic [W-1:0] exp_d [N];
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
    tick(1'b1, 1'b1, 1'b0, 32'h4433_2211);
    for (int k = 0; k < N; k++) begin
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL basic_valid k=%0d got=%b exp=1", k, valid); end
      checks++; if (d_out !== exp_d[k]) begin errors++; $display("FAIL basic_dout k=%0d got=%h exp=%h", k, d_out, exp_d[k]); end
      checks++; if (idx !== IW'(k)) begin errors++; $display("FAIL basic_idx k=%0d got=%0d exp=%0d", k, idx, k); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy k=%0d got=%b exp=1", k, busy); end
`ifdef READER_LAST_EN
      checks++; if (last !== (k == N-1)) begin errors++; $display("FAIL basic_last k=%0d got=%b exp=%b", k, last, (k == N-1)); end
`endif
      $display("xfer basic idx=%0d data=%h", idx, d_out);
      tick(1'b0, 1'b1, 1'b0, 32'h4433_2211);
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done got=%b exp=1", done); end
    checks++; if (valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL basic_donestate valid=%b busy=%b exp valid=0 busy=1", valid, busy); end
    tick(1'b0, 1'b1, 1'b0, 32'h4433_2211);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_idle done=%b busy=%b exp 0 0", done, busy); end
    checks++; if (d_out !== 8'h44) begin errors++; $display("FAIL basic_retain got=%h exp=44", d_out); end
  endtask

  task automatic test_backpressure();
    tick(1'b1, 1'b1, 1'b0, 32'h4433_2211);
    tick(1'b0, 1'b1, 1'b0, 32'h4433_2211);
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b0, 1'b0, 32'h4433_2211);
      checks++; if (d_out !== 8'h22 || idx !== IW'(1) || valid !== 1'b1) begin
        errors++; $display("FAIL bp_hold k=%0d got d=%h idx=%0d v=%b exp d=22 idx=1 v=1", k, d_out, idx, valid);
      end
    end
    tick(1'b0, 1'b1, 1'b0, 32'h4433_2211);
    checks++; if (d_out !== 8'h33 || idx !== IW'(2)) begin errors++; $display("FAIL bp_resume got d=%h idx=%0d exp d=33 idx=2", d_out, idx); end
    tick(1'b0, 1'b1, 1'b0, 32'h4433_2211);
    for (int k = 0; k < 2; k++) begin
      tick(1'b0, 1'b0, 1'b0, 32'h4433_2211);
      checks++; if (d_out !== 8'h44 || idx !== IW'(3) || valid !== 1'b1 || done !== 1'b0) begin
        errors++; $display("FAIL bp_lasthold k=%0d got d=%h idx=%0d v=%b done=%b", k, d_out, idx, valid, done);
      end
`ifdef READER_LAST_EN
      checks++; if (last !== 1'b1) begin errors++; $display("FAIL bp_last k=%0d got=%b exp=1", k, last); end
`endif
    end
    tick(1'b0, 1'b1, 1'b0, 32'h4433_2211);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done got=%b exp=1", done); end
    tick(1'b0, 1'b0, 1'b0, 32'h4433_2211);
  endtask

  task automatic test_isolation();
    logic [W-1:0] exp_d [N];
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
    tick(1'b1, 1'b1, 1'b0, 32'h4433_2211);
    for (int k = 0; k < N; k++) begin
      checks++; if (d_out !== exp_d[k] || valid !== 1'b1) begin
        errors++; $display("FAIL iso_dout k=%0d got=%h v=%b exp=%h", k, d_out, valid, exp_d[k]);
      end
      tick(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF);
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL iso_done got=%b exp=1", done); end
    tick(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF);
  endtask

  task automatic test_start_while_busy();
    int dones;
    dones = 0;
    tick(1'b1, 1'b1, 1'b0, 32'h4433_2211);
    checks++; if (d_out !== 8'h11) begin errors++; $display("FAIL swb_first got=%h exp=11", d_out); end
    tick(1'b1, 1'b1, 1'b0, 32'h8877_6655);
    checks++; if (d_out !== 8'h22 || idx !== IW'(1)) begin errors++; $display("FAIL swb_restart got d=%h idx=%0d exp d=22 idx=1", d_out, idx); end
    tick(1'b0, 1'b1, 1'b0, 32'h8877_6655);
    tick(1'b0, 1'b1, 1'b0, 32'h8877_6655);
    checks++; if (d_out !== 8'h44 || idx !== IW'(3)) begin errors++; $display("FAIL swb_seq got d=%h idx=%0d exp d=44 idx=3", d_out, idx); end
    tick(1'b1, 1'b1, 1'b0, 32'h8877_6655);
    if (done) dones++;
    tick(1'b1, 1'b1, 1'b0, 32'h8877_6655);
    if (done) dones++;
    checks++; if (valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL swb_donestart valid=%b busy=%b exp 0 0", valid, busy); end
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b1, 1'b0, 32'h8877_6655);
      if (done) dones++;
    end
    checks++; if (dones != 1) begin errors++; $display("FAIL swb_donecount got=%0d exp=1", dones); end
  endtask

  task automatic test_clear_mid();
    tick(1'b1, 1'b1, 1'b0, 32'h4433_2211);
    tick(1'b0, 1'b1, 1'b0, 32'h4433_2211);
    tick(1'b0, 1'b1, 1'b0, 32'h4433_2211);
    checks++; if (d_out !== 8'h33) begin errors++; $display("FAIL clr_pre got=%h exp=33", d_out); end
    tick(1'b0, 1'b1, 1'b1, 32'h4433_2211);
    checks++; if (valid !== 1'b0 || idx !== '0 || d_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL clr_state v=%b idx=%0d d=%h busy=%b done=%b exp all 0", valid, idx, d_out, busy, done);
    end
    tick(1'b0, 1'b1, 1'b0, 32'h4433_2211);
    checks++; if (done !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL clr_nodone done=%b v=%b exp 0 0", done, valid); end
    tick(1'b1, 1'b1, 1'b0, 32'hDDCC_BBAA);
    checks++; if (d_out !== 8'hAA || valid !== 1'b1 || idx !== '0) begin
      errors++; $display("FAIL clr_restart got d=%h v=%b idx=%0d exp d=aa v=1 idx=0", d_out, valid, idx);
    end
    for (int k = 0; k < N + 1; k++) tick(1'b0, 1'b1, 1'b0, 32'hDDCC_BBAA);
  endtask

  task automatic test_random();
    logic           s, r, c;
    logic [N*W-1:0] b;
    bit             ev;
    logic [IW-1:0]  ei;
    for (int cyc = 0; cyc < 400; cyc++) begin
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 2) != 0);
      c = ($urandom_range(0, 49) == 0);
      b = {$urandom, $urandom};
      if (valid && r && !c) $display("xfer rand idx=%0d data=%h", idx, d_out);
      tick(s, r, c, b);
      ev = (m_q.size() != 0);
      ei = ev ? IW'(N - m_q.size()) : '0;
      checks++; if (valid !== ev) begin errors++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", cyc, valid, ev); end
      checks++; if (idx !== ei) begin errors++; $display("FAIL rand_idx cyc=%0d got=%0d exp=%0d", cyc, idx, ei); end
      checks++; if (d_out !== m_d) begin errors++; $display("FAIL rand_dout cyc=%0d got=%h exp=%h", cyc, d_out, m_d); end
      checks++; if (done !== m_done) begin errors++; $display("FAIL rand_done cyc=%0d got=%b exp=%b", cyc, done, m_done); end
      checks++; if (busy !== (ev || m_done)) begin errors++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", cyc, busy, (ev || m_done)); end
`ifdef READER_LAST_EN
      checks++; if (last !== (m_q.size() == 1)) begin errors++; $display("FAIL rand_last cyc=%0d got=%b exp=%b", cyc, last, (m_q.size() == 1)); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_isolation();
    test_start_while_busy();
    test_clear_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_bank_reader.md
Name: reg_bank_reader

Overview:
- Read-side companion to the enable-written 8-bit register banks in the matrix datapath.
- On a start pulse, it snapshots a flat bank of N_ELEM words.
- It streams the words out one per accepted transfer over a valid/ready handshake, element 0 first.
- It flags completion with a one-cycle done pulse; downstream matrix units consume operands from it serially.

Parameters:
- N_ELEM, 4, number of words in the bank; legal range 2..16.
- WIDTH, 8, bits per word.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- clear  input  1  synchronous active-high reset.
- start  input  1  request to snapshot bank_in and begin streaming; honoured only in IDLE.
- bank_in  input  N_ELEM*WIDTH  flat bank; element i = bank_in[i*WIDTH +: WIDTH].
- d_out  output  WIDTH  current element.
- valid  output  1  d_out holds an element awaiting acceptance.
- ready  input  1  consumer accepts d_out at this edge when valid is high.
- idx  output  clog2(N_ELEM)  index of the element on d_out.
- busy  output  1  high in LOAD-completed streaming and DONE states, i.e. whenever state is not IDLE.
- done  output  1  one-cycle pulse after the final transfer.

Behaviour:
- Reset: clock and reset are fixed as one clock, clk; synchronous active-high reset, clear. clear sampled high at a rising edge forces the following:
  - state=IDLE;
  - d_out=0, valid=0, idx=0, busy=0, done=0;
  - snapshot storage=0.
- clear overrides every other input in the same edge, including mid-stream; no partial transfer completes and no done pulse is issued.
- States: IDLE, STREAM, DONE.
- IDLE:
  - valid=0, done=0, d_out retains its last value.
  - start=1 at an edge: snapshot all of bank_in into internal storage, idx=0, state->STREAM.
  - Latency: valid=1 with d_out=element 0 in the cycle immediately after the start edge.
- STREAM:
  - valid=1.
  - d_out=snapshot[idx], driven from registered storage (not combinationally from bank_in).
  - Transfer occurs at an edge where valid&&ready.
  - ready=0: d_out, idx and valid are held stable; no data change while valid is high without a transfer.
  - Transfer with idx<N_ELEM-1: idx+1, next element presented in the next cycle; back-to-back transfers at one per cycle when ready is held high.
  - Transfer with idx=N_ELEM-1: valid->0, idx->0, state->DONE.
- DONE:
  - done=1 for exactly one cycle, valid=0, busy=1; unconditionally ->IDLE next edge.
- start while state is not IDLE: ignored; no re-snapshot, no queuing.
- start in the DONE cycle: ignored. A new stream needs start in IDLE, giving a minimum start-to-start spacing of N_ELEM+2 cycles.
- Changes on bank_in after the snapshot edge do not affect the current stream.
- ready while valid=0: no effect.
- idx wraps only via the final-transfer rule, never by overflow.

Optional Feature:
- Macro: READER_LAST_EN.
- Defined: adds output port last (1 bit), which equals valid && (idx==N_ELEM-1).
  - Reset value 0.
  - Held with data while ready=0.
- Undefined: port last absent; all other behaviour identical.

Decomposition:
- Shared package holds:
  - default WIDTH constant (8);
  - state enum typedef (IDLE, STREAM, DONE) with fixed 2-bit encoding 00/01/10;
  - the clog2-based index-width function/constant.
- One natural sub-module: reader_snapshot_reg, a WIDTH-bit register with synchronous clear and load enable, instantiated N_ELEM times for the snapshot.
- FSM and output muxing stay in the top module.

Test Plan:
- Reset, then start=1 with bank_in=0x44_33_22_11, ready held 1:
  - cycle after start: valid=1, d_out=0x11;
  - then 0x22, 0x33, 0x44 on consecutive cycles, idx 0..3;
  - done pulse 1 cycle after the 0x44 transfer, then busy=0.
- Backpressure: same bank, ready=0 for 3 cycles while d_out=0x22 → d_out, idx=1 and valid held constant; resumes with 0x33 once ready=1.
- Snapshot isolation: start with 0x44_33_22_11, change bank_in to 0xFF_FF_FF_FF the next cycle → stream still emits 0x11, 0x22, 0x33, 0x44.
- Start while busy: pulse start during STREAM and in the DONE cycle → no restart, idx sequence unaffected, exactly one done pulse.
- Clear mid-stream: assert clear while d_out=0x33 → next cycle valid=0, idx=0, d_out=0, busy=0, no done. A subsequent start with 0xDD_CC_BB_AA streams 0xAA first.
- With READER_LAST_EN: last=1 only while d_out=0x44 is valid, including held backpressure cycles; 0 otherwise and after reset.
